// File: rtl/display_scroll_if.sv
// Character write stream from the message source into the scroll controller.
interface display_scroll_if;
   logic       wr_valid;
   logic [4:0] wr_char;
   logic       wr_last;
   logic       wr_ready;

   modport master (
      output wr_valid,
      output wr_char,
      output wr_last,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_char,
      input  wr_last,
      output wr_ready
   );
endinterface

// File: rtl/display_scroll_ctrl.sv
// Buffers a character message and presents a six-digit window of it to the
// seven-segment driver, statically for short messages and scrolling for long ones.
module display_scroll_ctrl #(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TICK_DIV = 25000000,
   parameter logic [4:0]  BLANK    = 5'd31
) (
   input  logic                   clk,
   input  logic                   rst,
   display_scroll_if.slave        wr_if,
   input  logic                   clear,
   input  logic                   loop_en,
   output logic [29:0]            data_out,
   output logic                   busy,
   output logic                   pass_done
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned CW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {StIdle, StLoad, StHold, StScroll} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [LW-1:0]   len_q, len_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [29:0]     data_out_q, data_out_d;
   logic [4:0]      buf_q [DEPTH];

   logic            accept;
   logic            tick;
   logic            at_end;
   logic            wr_en;
   logic [PW-1:0]   wr_idx;
   logic [LW-1:0]   len_inc;

   assign wr_if.wr_ready = ~rst & ~clear &
                           ((state_q == StIdle) | (state_q == StHold) |
                            ((state_q == StLoad) & (len_q < LW'(DEPTH))));
   assign accept = wr_if.wr_valid & wr_if.wr_ready;
   assign tick   = (cnt_q == CW'(TICK_DIV - 1));
   // Last window is reached when its leftmost digit shows buf[len-6].
   assign at_end = ({1'b0, pos_q} == (len_q - LW'(6)));

   assign busy     = ~rst & ((state_q == StLoad) | (state_q == StScroll));
   assign data_out = data_out_q;

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      wr_en     = 1'b0;
      wr_idx    = '0;
      len_inc   = len_q + 1'b1;
      pass_done = 1'b0;

      unique case (state_q)
         StIdle, StHold: begin
            if (accept) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               len_d   = LW'(1);
               pos_d   = '0;
               state_d = wr_if.wr_last ? StHold : StLoad;
            end
         end
         StLoad: begin
            if (accept) begin
               wr_en  = 1'b1;
               wr_idx = len_q[PW-1:0];
               len_d  = len_inc;
               pos_d  = '0;
               if (wr_if.wr_last || (len_inc == LW'(DEPTH))) begin
                  cnt_d   = '0;
                  state_d = (len_inc <= LW'(6)) ? StHold : StScroll;
               end
            end
         end
         StScroll: begin
            if (tick) begin
               cnt_d = '0;
               if (at_end) begin
                  pass_done = 1'b1;
                  if (loop_en) begin
                     pos_d = '0;
                  end else begin
                     state_d = StHold;
                  end
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (rst || clear) begin
         state_d   = StIdle;
         pos_d     = '0;
         len_d     = '0;
         cnt_d     = '0;
         wr_en     = 1'b0;
         pass_done = 1'b0;
      end
   end

   // Window seen by the driver next cycle, built from this cycle's registers.
   always_comb begin
      logic [LW-1:0] idx;
      data_out_d = {6{BLANK}};
      for (int k = 0; k < 6; k++) begin
         idx = LW'(pos_q) + LW'(5 - k);
         if ((state_q != StIdle) && (idx < len_q)) begin
            data_out_d[k*5 +: 5] = buf_q[idx[PW-1:0]];
         end
      end
      if (clear) begin
         data_out_d = {6{BLANK}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pos_q      <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         data_out_q <= {6{BLANK}};
      end else begin
         state_q    <= state_d;
         pos_q      <= pos_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         data_out_q <= data_out_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[wr_idx] <= wr_if.wr_char;
      end
   end

endmodule

// File: tb/tb_display_scroll_ctrl.sv
// Self-checking bench for display_scroll_ctrl: vector table, directed scroll
// sequences, then random traffic against a cycle-count based reference model.
module tb_display_scroll_ctrl;

   localparam int          TD = 4;
   localparam int          DP = 16;
   localparam logic [4:0]  B  = 5'd31;
   localparam logic [29:0] BL = {6{B}};

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        loop_en;
   logic [29:0] data_out;
   logic        busy;
   logic        pass_done;

   display_scroll_if wr_if ();

   display_scroll_ctrl #(
      .DEPTH    (DP),
      .TICK_DIV (TD),
      .BLANK    (B)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_if     (wr_if),
      .clear     (clear),
      .loop_en   (loop_en),
      .data_out  (data_out),
      .busy      (busy),
      .pass_done (pass_done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic        rst;
      logic        clr;
      logic        v;
      logic [4:0]  c;
      logic        l;
      logic        er;
      logic        eb;
      logic        ep;
      logic [29:0] ed;
   } vec_t;

   vec_t vecs [14];

   function automatic vec_t mk(input logic r, input logic cl, input logic v, input logic [4:0] c,
                               input logic l, input logic er, input logic eb, input logic ep,
                               input logic [29:0] ed);
      vec_t t;
      t.rst = r; t.clr = cl; t.v = v; t.c = c; t.l = l;
      t.er = er; t.eb = eb; t.ep = ep; t.ed = ed;
      return t;
   endfunction

   function automatic logic [29:0] w6(input logic [4:0] a5, input logic [4:0] a4,
                                      input logic [4:0] a3, input logic [4:0] a2,
                                      input logic [4:0] a1, input logic [4:0] a0);
      return {a5, a4, a3, a2, a1, a0};
   endfunction

   task automatic chk(input string nm, input logic [29:0] act, input logic [29:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] c, input logic l);
      wr_if.wr_valid = v;
      wr_if.wr_char  = c;
      wr_if.wr_last  = l;
   endtask

   task automatic nxt();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Presents n consecutive codes starting at first; returns at the first
   // cycle after the final acceptance.
   task automatic write_msg(input int n, input int first, input logic with_last);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 5'(first + i), with_last && (i == n - 1));
         nxt();
      end
      drive(1'b0, 5'd0, 1'b0);
   endtask

   // Reference model: message contents plus a cycle count since scrolling began.
   int          m_mode;   // 0 idle, 1 load, 2 hold, 3 scroll
   logic [4:0]  m_buf [DP];
   int          m_len;
   int          m_t;
   int          m_hold_pos;
   logic [29:0] m_disp;

   function automatic int m_pos();
      if (m_mode == 3) return (m_t / TD) % (m_len - 5);
      if (m_mode == 2) return m_hold_pos;
      return 0;
   endfunction

   function automatic logic [29:0] m_window();
      logic [29:0] w;
      int p;
      w = BL;
      if (m_mode == 0) return w;
      p = m_pos();
      for (int k = 0; k < 6; k++) begin
         if (p + 5 - k < m_len) w[k*5 +: 5] = m_buf[p + 5 - k];
      end
      return w;
   endfunction

   function automatic logic m_ready();
      return !rst && !clear && (m_mode == 0 || m_mode == 2 || (m_mode == 1 && m_len < DP));
   endfunction

   function automatic logic m_pass();
      return !rst && !clear && m_mode == 3 && (m_t % TD == TD - 1) &&
             ((m_t / TD) % (m_len - 5) == m_len - 6);
   endfunction

   task automatic m_step();
      logic [29:0] nd;
      logic acc, ps;
      nd  = (rst || clear) ? BL : m_window();
      acc = wr_if.wr_valid && m_ready();
      ps  = m_pass();
      if (rst || clear) begin
         m_mode = 0; m_len = 0; m_t = 0; m_hold_pos = 0;
      end else if (acc) begin
         if (m_mode == 0 || m_mode == 2) begin
            m_buf[0] = wr_if.wr_char;
            m_len = 1;
            m_hold_pos = 0;
            m_mode = wr_if.wr_last ? 2 : 1;
         end else begin
            m_buf[m_len] = wr_if.wr_char;
            m_len++;
            if (wr_if.wr_last || m_len == DP) begin
               if (m_len <= 6) begin
                  m_mode = 2; m_hold_pos = 0;
               end else begin
                  m_mode = 3; m_t = 0;
               end
            end
         end
      end else if (m_mode == 3) begin
         if (ps && !loop_en) begin
            m_mode = 2;
            m_hold_pos = m_len - 6;
         end else begin
            m_t++;
         end
      end
      if (rst) nd = BL;
      m_disp = nd;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic lp;
      rst = 1'b1; clear = 1'b0; loop_en = 1'b0;
      drive(1'b0, 5'd0, 1'b0);

      //        rst  clr  v    c      l    rdy  busy pass data
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, BL);
      vecs[1]  = mk(1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, BL);
      vecs[2]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BL);
      vecs[3]  = mk(1'b0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, BL);
      vecs[4]  = mk(1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, BL);
      vecs[5]  = mk(1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, w6(1, B, B, B, B, B));
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, w6(1, 2, B, B, B, B));
      vecs[7]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, w6(1, 2, 3, B, B, B));
      vecs[8]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, w6(1, 2, 3, B, B, B));
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, w6(1, 2, 3, B, B, B));
      vecs[10] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BL);
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, BL);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BL);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, w6(7, B, B, B, B, B));

      repeat (2) nxt();

      for (int i = 0; i < 14; i++) begin
         rst = vecs[i].rst; clear = vecs[i].clr;
         drive(vecs[i].v, vecs[i].c, vecs[i].l);
         #1;
         chk($sformatf("vec%0d ready", i), 30'(wr_if.wr_ready), 30'(vecs[i].er));
         chk($sformatf("vec%0d busy", i),  30'(busy),           30'(vecs[i].eb));
         chk($sformatf("vec%0d pass", i),  30'(pass_done),      30'(vecs[i].ep));
         chk($sformatf("vec%0d data", i),  data_out,            vecs[i].ed);
         nxt();
      end
      rst = 1'b0; clear = 1'b0;
      drive(1'b0, 5'd0, 1'b0);

      // Single pass of an eight-character message, then frozen on the last window.
      loop_en = 1'b0;
      write_msg(8, 0, 1'b1);
      for (int c = 0; c <= 20; c++) begin
         #1;
         chk($sformatf("once c%0d pass", c),  30'(pass_done),      30'(c == 11));
         chk($sformatf("once c%0d ready", c), 30'(wr_if.wr_ready), 30'(c >= 12));
         chk($sformatf("once c%0d busy", c),  30'(busy),           30'(c < 12));
         if (c == 0 || c == 4) chk($sformatf("once c%0d data", c), data_out, w6(0, 1, 2, 3, 4, 5));
         if (c == 5 || c == 8) chk($sformatf("once c%0d data", c), data_out, w6(1, 2, 3, 4, 5, 6));
         if (c == 9 || c >= 12) chk($sformatf("once c%0d data", c), data_out, w6(2, 3, 4, 5, 6, 7));
         nxt();
      end

      // Looping: window wraps back to the start after each pass.
      loop_en = 1'b1;
      write_msg(8, 0, 1'b1);
      for (int c = 0; c <= 37; c++) begin
         if (c == 24) loop_en = 1'b0;
         #1;
         chk($sformatf("loop c%0d pass", c), 30'(pass_done),
             30'(c == 11 || c == 23 || c == 35));
         chk($sformatf("loop c%0d busy", c), 30'(busy), 30'(c < 36));
         if (c == 12 || c == 37) chk($sformatf("loop c%0d data", c), data_out, w6(2, 3, 4, 5, 6, 7));
         if (c == 13) chk($sformatf("loop c%0d data", c), data_out, w6(0, 1, 2, 3, 4, 5));
         if (c == 17) chk($sformatf("loop c%0d data", c), data_out, w6(1, 2, 3, 4, 5, 6));
         nxt();
      end

      // Full buffer without wr_last; a seventeenth beat stalls through the scroll.
      for (int i = 0; i < DP; i++) begin
         drive(1'b1, 5'(i), 1'b0);
         #1;
         chk($sformatf("fill beat%0d ready", i), 30'(wr_if.wr_ready), 30'd1);
         nxt();
      end
      drive(1'b1, 5'd20, 1'b1);
      for (int c = 0; c <= 46; c++) begin
         if (c == 45) drive(1'b0, 5'd0, 1'b0);
         #1;
         if (c <= 44) chk($sformatf("full c%0d ready", c), 30'(wr_if.wr_ready), 30'(c == 44));
         chk($sformatf("full c%0d pass", c), 30'(pass_done), 30'(c == 43));
         chk($sformatf("full c%0d busy", c), 30'(busy),      30'(c < 44));
         if (c == 0)  chk("full c0 data", data_out, w6(0, 1, 2, 3, 4, 5));
         if (c == 44 || c == 45) chk($sformatf("full c%0d data", c), data_out, w6(10, 11, 12, 13, 14, 15));
         if (c == 46) chk("full c46 data", data_out, w6(20, B, B, B, B, B));
         nxt();
      end

      // Clear during scroll with a concurrent beat.
      loop_en = 1'b1;
      write_msg(8, 0, 1'b1);
      for (int c = 0; c <= 10; c++) begin
         if (c == 6) begin clear = 1'b1; drive(1'b1, 5'd9, 1'b0); end
         if (c == 7) begin clear = 1'b0; drive(1'b0, 5'd0, 1'b0); end
         if (c == 8) drive(1'b1, 5'd5, 1'b1);
         if (c == 9) drive(1'b0, 5'd0, 1'b0);
         #1;
         if (c == 6) chk("clr c6 ready", 30'(wr_if.wr_ready), 30'd0);
         if (c == 6) chk("clr c6 pass", 30'(pass_done), 30'd0);
         if (c == 7) chk("clr c7 busy", 30'(busy), 30'd0);
         if (c == 7 || c == 8 || c == 9) chk($sformatf("clr c%0d data", c), data_out, BL);
         if (c == 8) chk("clr c8 ready", 30'(wr_if.wr_ready), 30'd1);
         if (c == 10) chk("clr c10 data", data_out, w6(5, B, B, B, B, B));
         nxt();
      end

      // Random traffic against the reference model.
      rst = 1'b1; clear = 1'b0; loop_en = 1'b0;
      drive(1'b0, 5'd0, 1'b0);
      m_mode = 0; m_len = 0; m_t = 0; m_hold_pos = 0; m_disp = BL;
      nxt();
      lp = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rst   = ($urandom_range(0, 299) == 0);
         clear = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 49) == 0) lp = ~lp;
         loop_en = lp;
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               ($urandom_range(0, 9) == 0));
         #1;
         chk($sformatf("rnd c%0d ready", c), 30'(wr_if.wr_ready), 30'(m_ready()));
         chk($sformatf("rnd c%0d busy", c),  30'(busy),
             30'(!rst && (m_mode == 1 || m_mode == 3)));
         chk($sformatf("rnd c%0d pass", c),  30'(pass_done), 30'(m_pass()));
         chk($sformatf("rnd c%0d data", c),  data_out, m_disp);
         m_step();
         nxt();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
